// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the writeback/retire queue.
//   - load funct3 encodings (LB/LH/LW/LBU/LHU)
//   - wb_sel_e : result source select for non-load instructions
//   - wb_entry_t : one retire-queue slot
// ---------------------------------------------------------------------------
package wb_pkg;

   localparam int WB_XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_PC4 = 2'd1,
      WB_CSR = 2'd2,
      WB_IMM = 2'd3
   } wb_sel_e;

   typedef struct packed {
      logic               valid;
      logic               done;
      logic               is_load;
      logic               reg_we;
      logic [4:0]         rd;
      logic [2:0]         funct3;
      logic [1:0]         addr_lo;
      logic [WB_XLEN-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_retire_queue_ld_align.sv
// ---------------------------------------------------------------------------
// ld_align
// Combinational load data extraction and extension.
// Ports:
//   word    in  32  raw aligned memory word
//   funct3  in  3   load type
//   addr_lo in  2   byte offset inside the word
//   data    out 32  value to write to rd
// Unknown funct3 codes pass the whole word through.
// ---------------------------------------------------------------------------
module ld_align
   import wb_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   output logic [31:0] data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = word[7:0];
      case (addr_lo)
         2'd0: byte_v = word[7:0];
         2'd1: byte_v = word[15:8];
         2'd2: byte_v = word[23:16];
         2'd3: byte_v = word[31:24];
         default: byte_v = word[7:0];
      endcase
      // halfwords only use the upper offset bit; misaligned halves are not split
      half_v = addr_lo[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      data = word;
      case (funct3)
         F3_LB:   data = {{24{byte_v[7]}}, byte_v};
         F3_LH:   data = {{16{half_v[15]}}, half_v};
         F3_LW:   data = word;
         F3_LBU:  data = {24'd0, byte_v};
         F3_LHU:  data = {16'd0, half_v};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/wb_retire_queue.sv
// ---------------------------------------------------------------------------
// wb_retire_queue
// In-order writeback/retire unit. Instructions from MW enter an LQ_DEPTH-entry
// queue; loads complete out of order through tagged memory responses; the head
// retires to the register file one entry per cycle in program order.
//
// Optional feature (macro WB_BUSY_EN): adds rd_busy[31:0], a combinational
// mask of destination registers owned by valid queue entries with reg_we.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   MW instruction handshake
//   in_tag              slot index the next accepted entry receives
//   in_is_load, in_reg_we, in_rd, in_wb_sel, in_src_data, in_funct3, in_addr_lo
//                       instruction fields
//   mem_rsp_valid/_tag/_data  load data return (no backpressure)
//   rf_we, rf_rd, rf_wdata    registered register-file write port
//   rd_busy             (WB_BUSY_EN only) pending-destination mask
//
// Handshake: an instruction is accepted on a rising edge where in_valid and
// in_ready are both high. in_ready comes from the registered count only, so it
// never depends on in_valid or on a retire in the same cycle. Memory responses
// are always consumed: they either complete a waiting load or are dropped.
// ---------------------------------------------------------------------------
module wb_retire_queue
   import wb_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NUM_SRC  = 4,
   parameter int LQ_DEPTH = 4
)
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [$clog2(LQ_DEPTH)-1:0]   in_tag,
   input  logic                          in_is_load,
   input  logic                          in_reg_we,
   input  logic [4:0]                    in_rd,
   input  logic [$clog2(NUM_SRC)-1:0]    in_wb_sel,
   input  logic [NUM_SRC*XLEN-1:0]       in_src_data,
   input  logic [2:0]                    in_funct3,
   input  logic [1:0]                    in_addr_lo,
   input  logic                          mem_rsp_valid,
   input  logic [$clog2(LQ_DEPTH)-1:0]   mem_rsp_tag,
   input  logic [XLEN-1:0]               mem_rsp_data,
   output logic                          rf_we,
   output logic [4:0]                    rf_rd,
   output logic [XLEN-1:0]               rf_wdata
`ifdef WB_BUSY_EN
   ,
   output logic [31:0]                   rd_busy
`endif
);

   localparam int PTR_W = $clog2(LQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SEL_W = $clog2(NUM_SRC);

   wb_entry_t        q [LQ_DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] count;

   logic             accept;
   logic             retire;
   logic             rsp_hit;
   logic [XLEN-1:0]  src_sel;
   logic [31:0]      rsp_aligned;
   wb_entry_t        new_ent;

   assign in_ready = (count != CNT_W'(LQ_DEPTH));
   assign in_tag   = wptr;
   assign accept   = in_valid && in_ready;
   // head must be both present and complete; a pending head blocks younger entries
   assign retire   = q[rptr].valid && q[rptr].done;
   // only a waiting load may be completed; stale or duplicate tags fall through
   assign rsp_hit  = mem_rsp_valid && q[mem_rsp_tag].valid &&
                     q[mem_rsp_tag].is_load && !q[mem_rsp_tag].done;

   always_comb begin
      src_sel = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (in_wb_sel == SEL_W'(s)) src_sel = in_src_data[s*XLEN +: XLEN];
      end
   end

   always_comb begin
      new_ent         = '0;
      new_ent.valid   = 1'b1;
      new_ent.done    = !in_is_load;
      new_ent.is_load = in_is_load;
      new_ent.reg_we  = in_reg_we;
      new_ent.rd      = in_rd;
      new_ent.funct3  = in_funct3;
      new_ent.addr_lo = in_addr_lo;
      new_ent.data    = in_is_load ? '0 : src_sel;
   end

   ld_align u_ld_align (
      .word    (mem_rsp_data),
      .funct3  (q[mem_rsp_tag].funct3),
      .addr_lo (q[mem_rsp_tag].addr_lo),
      .data    (rsp_aligned)
   );

   // Slot collisions between the three updates are impossible: an accept
   // targets an invalid slot, a response needs a not-done entry while retire
   // needs a done one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         rf_we    <= 1'b0;
         rf_rd    <= '0;
         rf_wdata <= '0;
         for (int i = 0; i < LQ_DEPTH; i++) q[i] <= '0;
      end else begin
         if (rsp_hit) begin
            q[mem_rsp_tag].data <= rsp_aligned;
            q[mem_rsp_tag].done <= 1'b1;
         end

         if (retire) begin
            q[rptr].valid <= 1'b0;
            rf_we         <= q[rptr].reg_we && (q[rptr].rd != 5'd0);
            rf_rd         <= q[rptr].rd;
            rf_wdata      <= q[rptr].data;
            rptr          <= rptr + PTR_W'(1);
         end else begin
            rf_we <= 1'b0;
         end

         if (accept) begin
            q[wptr] <= new_ent;
            wptr    <= wptr + PTR_W'(1);
         end

         case ({accept, retire})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef WB_BUSY_EN
   always_comb begin
      rd_busy = '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         if (q[i].valid && q[i].reg_we) rd_busy[q[i].rd] = 1'b1;
      end
      rd_busy[0] = 1'b0; // x0 is never a hazard
   end
`endif

endmodule

// File: tb/tb_wb_retire_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_retire_queue
// Self-checking bench for wb_retire_queue: a table of single-instruction
// vectors plus hand-written sequences for reset flush, out-of-order load
// completion, full queue / tag wrap and (with WB_BUSY_EN) the busy mask.
// Expected register writes go into exp_q when an instruction is accepted and
// are popped by the monitor whenever rf_we is seen.
// ---------------------------------------------------------------------------
module tb_wb_retire_queue;
   import wb_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_tag;
   logic         in_is_load;
   logic         in_reg_we;
   logic [4:0]   in_rd;
   logic [1:0]   in_wb_sel;
   logic [127:0] in_src_data;
   logic [2:0]   in_funct3;
   logic [1:0]   in_addr_lo;
   logic         mem_rsp_valid;
   logic [1:0]   mem_rsp_tag;
   logic [31:0]  mem_rsp_data;
   logic         rf_we;
   logic [4:0]   rf_rd;
   logic [31:0]  rf_wdata;
`ifdef WB_BUSY_EN
   logic [31:0]  rd_busy;
`endif

   wb_retire_queue dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_tag        (in_tag),
      .in_is_load    (in_is_load),
      .in_reg_we     (in_reg_we),
      .in_rd         (in_rd),
      .in_wb_sel     (in_wb_sel),
      .in_src_data   (in_src_data),
      .in_funct3     (in_funct3),
      .in_addr_lo    (in_addr_lo),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_tag   (mem_rsp_tag),
      .mem_rsp_data  (mem_rsp_data),
      .rf_we         (rf_we),
      .rf_rd         (rf_rd),
      .rf_wdata      (rf_wdata)
`ifdef WB_BUSY_EN
      ,
      .rd_busy       (rd_busy)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [36:0] exp_q[$];   // {rd, data}
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_write", rf_we, 1'b0);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("wb_rd", rf_rd, e[36:32]);
            check("wb_data", rf_wdata, e[31:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst_n         = 1'b0;
      in_valid      = 1'b0;
      mem_rsp_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic drive_instr(input logic ld, input logic we, input logic [4:0] rd,
                              input wb_sel_e sel, input logic [31:0] val,
                              input logic [2:0] f3, input logic [1:0] alo);
      in_valid   = 1'b1;
      in_is_load = ld;
      in_reg_we  = we;
      in_rd      = rd;
      in_wb_sel  = sel;
      in_funct3  = f3;
      in_addr_lo = alo;
      for (int s = 0; s < 4; s++)
         in_src_data[s*32 +: 32] = (s == int'(sel)) ? val : $urandom;
   endtask

   task automatic issue(input logic ld, input logic we, input logic [4:0] rd,
                        input wb_sel_e sel, input logic [31:0] val,
                        input logic [2:0] f3, input logic [1:0] alo,
                        input logic [31:0] exp_data, output logic [1:0] tag);
      int c = 0;
      while (in_ready !== 1'b1 && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      if (in_ready !== 1'b1) begin
         check("issue_timeout", in_ready, 1'b1);
         tag = 2'd0;
      end else begin
         drive_instr(ld, we, rd, sel, val, f3, alo);
         tag = in_tag;
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (we && rd != 5'd0) exp_q.push_back({rd, exp_data});
      end
   endtask

   task automatic respond(input logic [1:0] tag, input logic [31:0] word);
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = tag;
      mem_rsp_data  = word;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int c = 0;
      do begin
         @(posedge clk); #1;
         c++;
      end while (exp_q.size() != 0 && c < 100);
      check("drain_pending", exp_q.size(), 0);
   endtask

   task automatic expect_quiet(input string name, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         check(name, rf_we, 1'b0);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        ld;
      wb_sel_e     sel;
      logic [31:0] val;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [1:0]  alo;
      logic [31:0] word;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic [1:0] t0, t2, t4, tg;
      rst_n = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_reg_we = 1'b0;
      in_rd = '0; in_wb_sel = '0; in_src_data = '0; in_funct3 = '0;
      in_addr_lo = '0; mem_rsp_valid = 1'b0; mem_rsp_tag = '0; mem_rsp_data = '0;

      vecs[0]  = '{1'b0, WB_ALU, 32'h0000_1234, 5'd5,  F3_LW,  2'd0, 32'h0,         32'h0000_1234};
      vecs[1]  = '{1'b0, WB_PC4, 32'hDEAD_BEEF, 5'd6,  F3_LW,  2'd0, 32'h0,         32'hDEAD_BEEF};
      vecs[2]  = '{1'b0, WB_CSR, 32'h0000_0300, 5'd7,  F3_LW,  2'd0, 32'h0,         32'h0000_0300};
      vecs[3]  = '{1'b0, WB_IMM, 32'hFFFF_F000, 5'd8,  F3_LW,  2'd0, 32'h0,         32'hFFFF_F000};
      vecs[4]  = '{1'b1, WB_ALU, 32'h0,         5'd10, F3_LB,  2'd3, 32'h80FF_0000, 32'hFFFF_FF80};
      vecs[5]  = '{1'b1, WB_ALU, 32'h0,         5'd11, F3_LHU, 2'd2, 32'h80FF_0000, 32'h0000_80FF};
      vecs[6]  = '{1'b1, WB_ALU, 32'h0,         5'd12, F3_LW,  2'd1, 32'h80FF_0000, 32'h80FF_0000};
      vecs[7]  = '{1'b1, WB_ALU, 32'h0,         5'd13, F3_LBU, 2'd2, 32'h80FF_0000, 32'h0000_00FF};
      vecs[8]  = '{1'b1, WB_ALU, 32'h0,         5'd14, F3_LH,  2'd0, 32'h1234_8001, 32'hFFFF_8001};
      vecs[9]  = '{1'b1, WB_ALU, 32'h0,         5'd15, F3_LB,  2'd1, 32'h0000_7F00, 32'h0000_007F};
      vecs[10] = '{1'b1, WB_ALU, 32'h0,         5'd16, 3'b011, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D};
      vecs[11] = '{1'b1, WB_ALU, 32'h0,         5'd17, F3_LBU, 2'd0, 32'h0000_00AB, 32'h0000_00AB};
      vecs[12] = '{1'b1, WB_ALU, 32'h0,         5'd18, F3_LH,  2'd2, 32'h7FFF_0000, 32'h0000_7FFF};

      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // ---- reset while three loads are pending ----
      issue(1'b1, 1'b1, 5'd11, WB_ALU, 32'h0, F3_LW, 2'd0, 32'h0, tg);
      issue(1'b1, 1'b1, 5'd12, WB_ALU, 32'h0, F3_LW, 2'd0, 32'h0, tg);
      issue(1'b1, 1'b1, 5'd13, WB_ALU, 32'h0, F3_LW, 2'd0, 32'h0, tg);
      do_reset();
      @(negedge clk);
      check("rst_rf_we", rf_we, 1'b0);
      check("rst_rf_rd", rf_rd, 5'd0);
      check("rst_rf_wdata", rf_wdata, 32'h0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_in_tag", in_tag, 2'd0);
      respond(2'd1, 32'h5555_5555);
      expect_quiet("flushed_rsp", 3);

      // ---- out-of-order completion, in-order retire ----
      @(posedge clk); #1;
      issue(1'b1, 1'b1, 5'd1, WB_ALU, 32'h0,         F3_LW, 2'd0, 32'h1111_1111, t0);
      issue(1'b0, 1'b1, 5'd2, WB_ALU, 32'h0000_2222, F3_LW, 2'd0, 32'h0000_2222, tg);
      issue(1'b1, 1'b1, 5'd3, WB_ALU, 32'h0,         F3_LW, 2'd0, 32'h3333_3333, t2);
      check("ooo_tag0", t0, 2'd0);
      check("ooo_tag2", t2, 2'd2);
      respond(t2, 32'h3333_3333);
      expect_quiet("head_blocked", 3);
      respond(t0, 32'h1111_1111);
      wait_drain();

      // ---- response to head in the same edge as an unrelated accept ----
      issue(1'b1, 1'b1, 5'd4, WB_ALU, 32'h0, F3_LW, 2'd0, 32'h4444_4444, t4);
      @(posedge clk); #1;
      drive_instr(1'b0, 1'b1, 5'd20, WB_CSR, 32'h0000_2020, F3_LW, 2'd0);
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = t4;
      mem_rsp_data  = 32'h4444_4444;
      @(posedge clk); #1;
      in_valid      = 1'b0;
      mem_rsp_valid = 1'b0;
      exp_q.push_back({5'd20, 32'h0000_2020});
      wait_drain();

      // ---- table-driven single instructions with latency checks ----
      for (int i = 0; i < 13; i++) begin
         issue(vecs[i].ld, 1'b1, vecs[i].rd, vecs[i].sel, vecs[i].val,
               vecs[i].f3, vecs[i].alo, vecs[i].exp, tg);
         if (vecs[i].ld) begin
            expect_quiet("load_waits", 2);
            @(posedge clk); #1;
            respond(tg, vecs[i].word);
         end
         @(negedge clk);
         check("lat_early", rf_we, 1'b0);
         @(negedge clk);
         check("lat_on", rf_we, 1'b1);
         wait_drain();
      end

      // ---- full queue, tag wrap, rd=0 and reg_we=0 ----
      do_reset();
      issue(1'b1, 1'b1, 5'd14, WB_ALU, 32'h0, F3_LW,  2'd0, 32'hAAAA_0001, tg);
      issue(1'b1, 1'b1, 5'd0,  WB_ALU, 32'h0, F3_LW,  2'd0, 32'h0,         tg);
      issue(1'b1, 1'b0, 5'd15, WB_ALU, 32'h0, F3_LW,  2'd0, 32'h0,         tg);
      issue(1'b1, 1'b1, 5'd16, WB_ALU, 32'h0, F3_LBU, 2'd1, 32'h0000_005A, tg);
      check("fill_last_tag", tg, 2'd3);
      check("full_in_ready", in_ready, 1'b0);
      check("full_tag_wrap", in_tag, 2'd0);
      respond(2'd0, 32'hAAAA_0001);
      @(negedge clk);
      check("full_while_retiring", in_ready, 1'b0);
      @(negedge clk);
      check("ready_after_retire", in_ready, 1'b1);
      issue(1'b0, 1'b1, 5'd0, WB_ALU, 32'h0000_0005, F3_LW, 2'd0, 32'h0, tg);
      check("wrapped_tag", tg, 2'd0);
      respond(2'd1, 32'hBBBB_BBBB);
      respond(2'd2, 32'hCCCC_CCCC);
      respond(2'd3, 32'h0000_5A00);
      wait_drain();
      expect_quiet("rd0_no_write", 4);

`ifdef WB_BUSY_EN
      // ---- busy mask ----
      do_reset();
      issue(1'b1, 1'b1, 5'd7, WB_ALU, 32'h0, F3_LW, 2'd0, 32'h7777_7777, t0);
      issue(1'b1, 1'b1, 5'd9, WB_ALU, 32'h0, F3_LW, 2'd0, 32'h9999_9999, tg);
      issue(1'b1, 1'b1, 5'd0, WB_ALU, 32'h0, F3_LW, 2'd0, 32'h0,         t2);
      @(negedge clk);
      check("rd_busy_pending", rd_busy, 32'h0000_0280);
      respond(t0, 32'h7777_7777);
      respond(tg, 32'h9999_9999);
      respond(t2, 32'h0);
      wait_drain();
      repeat (3) @(posedge clk);
      #1;
      check("rd_busy_clear", rd_busy, 32'h0);
`endif

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
